// File: rtl/data_mem_ctrl.sv
// Data memory controller: word array at BASE_ADDR with byte/half/word access,
// programmable latency, valid/ready request port and a one-cycle response strobe.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_in, req_q, req_d, cur;
  logic              ready_d, rsp_valid_d, rsp_err_d;
  logic [31:0]       rsp_rdata_d;
  logic              enter_resp, mem_we;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              err;
  logic [31:0]       old_word, lane_mask, lane_data, load_val, mem_wword;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;

  assign req_in = '{write: req_write, size: req_size, uns: req_unsigned,
                    addr: req_addr, wdata: req_wdata};

  // Address decode, fault detection, lane extraction and store merge.
  // With LATENCY==1 the access completes on the accept edge, so decode the live request in IDLE.
  always_comb begin
    cur       = (state_q == IDLE) ? req_in : req_q;
    off       = cur.addr - BASE;
    idx       = off[IDX_W+1:2];
    lane      = off[1:0];
    old_word  = mem[idx];
    err       = (off >= SPAN) || (cur.size == 2'b11) ||
                ((cur.size == 2'b01) && off[0]) ||
                ((cur.size == 2'b10) && (lane != 2'b00));
    rd_byte   = old_word[{lane, 3'b000} +: 8];
    rd_half   = lane[1] ? old_word[31:16] : old_word[15:0];
    lane_mask = '0;
    lane_data = '0;
    load_val  = '0;
    case (cur.size)
      2'b00: begin
        lane_mask = 32'h0000_00FF << {lane, 3'b000};
        lane_data = {4{cur.wdata[7:0]}};
        load_val  = {{24{rd_byte[7] & ~cur.uns}}, rd_byte};
      end
      2'b01: begin
        lane_mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        lane_data = {2{cur.wdata[15:0]}};
        load_val  = {{16{rd_half[15] & ~cur.uns}}, rd_half};
      end
      2'b10: begin
        lane_mask = '1;
        lane_data = cur.wdata;
        load_val  = old_word;
      end
      default: ;
    endcase
    mem_wword = (old_word & ~lane_mask) | (lane_data & lane_mask);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    enter_resp  = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d = req_in;
          if (LATENCY == 1) begin
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) enter_resp = 1'b1;
        else                    cnt_d      = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = err;
      rsp_rdata_d = (err || cur.write) ? 32'h0 : load_val;
      mem_we      = cur.write && !err;
    end
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      req_ready <= ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  // Storage array; deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= mem_wword;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: instance 0 has LATENCY=1, instance 1 has LATENCY=3;
// each is checked against a byte-array reference model.
module tb_data_mem_ctrl;

  logic        clk;
  logic [1:0]  rst, req_valid, req_ready, req_write, req_unsigned, rsp_valid, rsp_err;
  logic [1:0]  req_size [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  int checks;
  int errors;
  int lat_of [2] = '{1, 3};

  logic [7:0] mdl [2][256];

  data_mem_ctrl #(.ADDR_W(32), .BASE_ADDR(1024), .DEPTH_WORDS(64), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  data_mem_ctrl #(.ADDR_W(32), .BASE_ADDR(1024), .DEPTH_WORDS(64), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: memory as 256 bytes, accesses as little-endian byte sequences.
  function automatic void model(input int d, input logic w, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                output logic e_err, output logic [31:0] e_rdata);
    logic [31:0] off;
    logic [31:0] v;
    int n;
    off = addr - 32'd1024;
    n = 1 << sz;
    e_err = (off >= 32'd256) || (sz == 2'b11) || ((off % n) != 0);
    e_rdata = 32'h0;
    if (!e_err) begin
      if (w) begin
        for (int i = 0; i < n; i++) mdl[d][int'(off) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[d][int'(off) + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
        e_rdata = v;
      end
    end
  endfunction

  // Issue one request from IDLE and observe until the controller is ready again.
  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic o_err, output logic [31:0] o_rdata,
                        output int lat, output int busy, output int pulses);
    bit seen;
    req_write[d] = w; req_size[d] = sz; req_unsigned[d] = uns;
    req_addr[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    seen = 0; lat = 0; busy = 0; pulses = 0; o_err = 1'bx; o_rdata = 32'hx;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid[d]) begin
        pulses++;
        if (!seen) begin seen = 1; lat = k; o_err = rsp_err[d]; o_rdata = rsp_rdata[d]; end
      end
      if (!req_ready[d]) busy++;
      if (seen && req_ready[d]) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 2'b11;
    #7;
    rst = 2'b00;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values[%0d]: ready=%b valid=%b rdata=%h err=%b expected 1 0 00000000 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 2'b11;
  endtask

  task automatic test_fill();
    logic e, ee; logic [31:0] r, er, data; int lat, busy, pul;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++) begin
        data = $urandom;
        model(d, 1'b1, 2'b10, 1'b0, 32'd1024 + 32'(4 * w), data, ee, er);
        access(d, 1'b1, 2'b10, 1'b0, 32'd1024 + 32'(4 * w), data, e, r, lat, busy, pul);
        checks++;
        if (e !== ee || r !== er || lat != lat_of[d] || pul != 1) begin
          errors++;
          $display("FAIL fill[%0d] word %0d: err=%b rdata=%h lat=%0d pulses=%0d expected %b %h %0d 1",
                   d, w, e, r, lat, pul, ee, er, lat_of[d]);
        end
      end
    end
  endtask

  task automatic test_lat1_word();
    logic e, ee; logic [31:0] r, er; int lat, busy, pul;
    model(0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'hDEADBEEF, ee, er);
    access(0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'hDEADBEEF, e, r, lat, busy, pul);
    checks++;
    if (e !== 1'b0 || r !== 32'h0 || lat != 1 || busy != 1 || pul != 1) begin
      errors++;
      $display("FAIL lat1_store: err=%b rdata=%h lat=%0d busy=%0d pulses=%0d expected 0 00000000 1 1 1",
               e, r, lat, busy, pul);
    end
    access(0, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, e, r, lat, busy, pul);
    checks++;
    if (e !== 1'b0 || r !== 32'hDEADBEEF || lat != 1 || busy != 1 || pul != 1) begin
      errors++;
      $display("FAIL lat1_load: err=%b rdata=%h lat=%0d busy=%0d pulses=%0d expected 0 deadbeef 1 1 1",
               e, r, lat, busy, pul);
    end
    checks++;
    if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rdata_hold: valid=%b rdata=%h expected 0 deadbeef", rsp_valid[0], rsp_rdata[0]);
    end
  endtask

  task automatic test_byte_ext();
    logic e, ee; logic [31:0] r, er; int lat, busy, pul;
    logic [31:0] exp_const [3] = '{32'hFFFFFF80, 32'h00000080, 32'hDEAD80EF};
    logic [1:0]  szs [3] = '{2'b00, 2'b00, 2'b10};
    logic        unss [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] addrs [3] = '{32'd1025, 32'd1025, 32'd1024};
    model(0, 1'b1, 2'b00, 1'b0, 32'd1025, 32'h00000080, ee, er);
    access(0, 1'b1, 2'b00, 1'b0, 32'd1025, 32'h00000080, e, r, lat, busy, pul);
    checks++;
    if (e !== 1'b0 || r !== 32'h0) begin
      errors++;
      $display("FAIL byte_store: err=%b rdata=%h expected 0 00000000", e, r);
    end
    for (int i = 0; i < 3; i++) begin
      model(0, 1'b0, szs[i], unss[i], addrs[i], 32'h0, ee, er);
      access(0, 1'b0, szs[i], unss[i], addrs[i], 32'h0, e, r, lat, busy, pul);
      checks++;
      if (e !== 1'b0 || r !== exp_const[i] || r !== er) begin
        errors++;
        $display("FAIL byte_ext[%0d]: err=%b rdata=%h expected 0 %h", i, e, r, exp_const[i]);
      end
    end
  endtask

  task automatic test_faults();
    logic e, ee; logic [31:0] r, er; int lat, busy, pul;
    logic        ws [7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  szs [7] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b10, 2'b00, 2'b10};
    logic [31:0] as [7]  = '{32'd1027, 32'd1280, 32'd1020, 32'd1024, 32'd1026, 32'hFFFFFFFF, 32'd1276};
    for (int i = 0; i < 7; i++) begin
      model(0, ws[i], szs[i], 1'b0, as[i], 32'h12345678, ee, er);
      access(0, ws[i], szs[i], 1'b0, as[i], 32'h12345678, e, r, lat, busy, pul);
      checks++;
      if (e !== ee || r !== er || ee !== (i != 6) || lat != 1) begin
        errors++;
        $display("FAIL fault[%0d] addr=%0d: err=%b rdata=%h lat=%0d expected %b %h 1",
                 i, as[i], e, r, lat, ee, er);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ee; logic [31:0] er, r1, r2; int rmask, ymask;
    model(1, 1'b0, 2'b10, 1'b0, 32'd1100, 32'h0, ee, er);
    req_write[1] = 1'b0; req_size[1] = 2'b10; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'd1100; req_wdata[1] = 32'h0; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    rmask = 0; ymask = 0; r1 = 32'hx; r2 = 32'hx;
    for (int k = 1; k <= 8; k++) begin
      if (rsp_valid[1]) rmask |= (1 << k);
      if (req_ready[1]) ymask |= (1 << k);
      if (k == 3) r1 = rsp_rdata[1];
      if (k == 7) r2 = rsp_rdata[1];
      if (k == 8) req_valid[1] = 1'b0;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (rmask != ((1 << 3) | (1 << 7))) begin
      errors++;
      $display("FAIL b2b_valid_cycles: mask=%b expected %b", 9'(rmask), 9'((1 << 3) | (1 << 7)));
    end
    checks++;
    if (ymask != ((1 << 4) | (1 << 8))) begin
      errors++;
      $display("FAIL b2b_ready_cycles: mask=%b expected %b", 9'(ymask), 9'((1 << 4) | (1 << 8)));
    end
    checks++;
    if (r1 !== er || r2 !== er) begin
      errors++;
      $display("FAIL b2b_rdata: first=%h second=%h expected %h", r1, r2, er);
    end
  endtask

  task automatic test_reset_mid();
    logic e, ee; logic [31:0] r, er; int lat, busy, pul; bit stray;
    model(1, 1'b1, 2'b10, 1'b0, 32'd1028, 32'h11111111, ee, er);
    access(1, 1'b1, 2'b10, 1'b0, 32'd1028, 32'h11111111, e, r, lat, busy, pul);
    checks++;
    if (e !== 1'b0 || lat != 3 || busy != 3 || pul != 1) begin
      errors++;
      $display("FAIL lat3_store: err=%b lat=%0d busy=%0d pulses=%0d expected 0 3 3 1", e, lat, busy, pul);
    end
    req_write[1] = 1'b1; req_size[1] = 2'b10; req_addr[1] = 32'd1028;
    req_wdata[1] = 32'h22222222; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    #2;
    rst[1] = 1'b0;
    #1;
    checks++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_err[1] !== 1'b0 || rsp_rdata[1] !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset: ready=%b valid=%b err=%b rdata=%h expected 1 0 0 00000000",
               req_ready[1], rsp_valid[1], rsp_err[1], rsp_rdata[1]);
    end
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) stray = 1;
      if (k == 1) rst[1] = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL midop_no_rsp: rsp_valid=1 seen, expected 0");
    end
    model(1, 1'b0, 2'b10, 1'b0, 32'd1028, 32'h0, ee, er);
    access(1, 1'b0, 2'b10, 1'b0, 32'd1028, 32'h0, e, r, lat, busy, pul);
    checks++;
    if (e !== 1'b0 || r !== 32'h11111111 || r !== er || lat != 3) begin
      errors++;
      $display("FAIL midop_not_committed: err=%b rdata=%h lat=%0d expected 0 11111111 3", e, r, lat);
    end
  endtask

  task automatic test_random();
    logic e, ee, w, uns; logic [1:0] sz; logic [31:0] r, er, addr, wd; int lat, busy, pul;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        w   = 1'($urandom_range(0, 1));
        uns = 1'($urandom_range(0, 1));
        sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        addr = 32'd1016 + 32'($urandom_range(0, 271));
        if ($urandom_range(0, 3) != 0 && sz != 2'b11) addr = addr & ~((32'd1 << sz) - 32'd1);
        wd = $urandom;
        model(d, w, sz, uns, addr, wd, ee, er);
        access(d, w, sz, uns, addr, wd, e, r, lat, busy, pul);
        checks++;
        if (e !== ee || r !== er || lat != lat_of[d] || busy != lat_of[d] || pul != 1) begin
          errors++;
          $display("FAIL random[%0d.%0d] w=%b sz=%0d u=%b addr=%0d: err=%b rdata=%h lat=%0d busy=%0d pulses=%0d expected %b %h %0d %0d 1",
                   d, i, w, sz, uns, addr, e, r, lat, busy, pul, ee, er, lat_of[d], lat_of[d]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 2'b11;
    req_valid = '0; req_write = '0; req_unsigned = '0;
    for (int d = 0; d < 2; d++) begin
      req_size[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    test_reset();
    test_fill();
    test_lat1_word();
    test_byte_ext();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
